instruction_fetch_unit: RTL

Fetch-side initiator for the instruction memory: owns the program counter, drives the word address into the combinational-read instruction memory, and captures each returned instruction with its PC into a small prefetch queue. The queue feeds the IF/ID boundary through a valid/ready handshake, so decode-side stalls never drop or duplicate an instruction. A redirect input from the branch/jump resolution stage flushes the queue and restarts fetch at the target.

---
 rtl/instruction_fetch_unit_if.sv | 57 +++++
 rtl/instruction_fetch_unit.sv | 88 ++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch bus: imem port, redirect input and IF/ID valid/ready handshake.
// FetchCount/StallCount exist only when IFU_PERF_COUNT_EN is defined.
interface instruction_fetch_unit_if #(
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W = $clog2(QUEUE_DEPTH) + 1
);
  logic [31:0]      IMemAddress;
  logic [31:0]      IMemInstruction;
  logic             Redirect;
  logic [31:0]      RedirectTarget;
  logic             OutValid;
  logic             OutReady;
  logic [31:0]      OutInstruction;
  logic [31:0]      OutPC;
  logic [31:0]      OutPCPlus4;
  logic [CNT_W-1:0] QueueCount;
`ifdef IFU_PERF_COUNT_EN
  logic [31:0]      FetchCount;
  logic [31:0]      StallCount;
`endif

  modport master (
    output IMemAddress,
    input  IMemInstruction,
    input  Redirect,
    input  RedirectTarget,
    output OutValid,
    input  OutReady,
    output OutInstruction,
    output OutPC,
    output OutPCPlus4,
    output QueueCount
`ifdef IFU_PERF_COUNT_EN
    ,
    output FetchCount,
    output StallCount
`endif
  );

  modport slave (
    input  IMemAddress,
    output IMemInstruction,
    output Redirect,
    output RedirectTarget,
    input  OutValid,
    output OutReady,
    input  OutInstruction,
    input  OutPC,
    input  OutPCPlus4,
    input  QueueCount
`ifdef IFU_PERF_COUNT_EN
    ,
    input  FetchCount,
    input  StallCount
`endif
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC owner + prefetch queue feeding IF/ID over valid/ready.
// Optional perf counters under IFU_PERF_COUNT_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QUEUE_DEPTH = 4,
  parameter int CNT_W = $clog2(QUEUE_DEPTH) + 1
) (
  input logic Clk,
  input logic Reset,
  instruction_fetch_unit_if.master bus
);
  localparam int PTR_W = CNT_W - 1;
  localparam logic [31:0] BOOT_PC = RESET_PC & ~32'h3;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      q_ins [QUEUE_DEPTH];
  logic [31:0]      q_pc  [QUEUE_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push;

  assign full = (count == FULL);
  assign pop  = bus.OutValid & bus.OutReady;
  // a full queue still accepts a fetch when the head leaves
  assign push = !full | pop;

  assign bus.IMemAddress    = fetch_pc;
  assign bus.OutValid       = (count != '0);
  assign bus.OutInstruction = q_ins[head];
  assign bus.OutPC          = q_pc[head];
  assign bus.OutPCPlus4     = q_pc[head] + 32'd4;
  assign bus.QueueCount     = count;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fetch_pc <= BOOT_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_ins[i] <= '0;
        q_pc[i]  <= '0;
      end
    end else if (bus.Redirect) begin
      fetch_pc <= bus.RedirectTarget & ~32'h3;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        q_ins[tail] <= bus.IMemInstruction;
        q_pc[tail]  <= fetch_pc;
        tail        <= tail + PTR_W'(1);
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef IFU_PERF_COUNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (push && !bus.Redirect) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (full && !pop) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign bus.FetchCount = fetch_cnt;
  assign bus.StallCount = stall_cnt;
`endif
endmodule
